// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: frames an address/command pair as leader, 32 pulse-distance bits and stop mark.
// Optional NEC repeat frames while tx_hold is asserted are built when IR_NEC_REPEAT_EN is defined.
//
// state      | meaning
// IDLE       | waiting for tx_valid, tx_ready=1
// LEAD_MARK  | 16u leader mark
// LEAD_SPACE | 8u leader space
// BIT_MARK   | 1u mark preceding every data bit
// BIT_SPACE  | 1u (bit 0) or 3u (bit 1) space
// STOP_MARK  | 1u trailing mark
// GAP        | silence until FRAME_UNITS after the frame/repeat start
// REP_MARK   | 16u repeat mark
// REP_SPACE  | 4u repeat space
// REP_STOP   | 1u repeat stop mark
module ir_nec_tx #(
  parameter int UNIT_CYC     = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439,
  parameter int FRAME_UNITS  = 192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_hold,
  output logic       ir_out,
  output logic       ir_env,
  output logic       busy,
  output logic       tx_done
);

  localparam int CYC_W = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int PH_W  = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP,
    REP_MARK, REP_SPACE, REP_STOP
  } state_t;

  state_t             state, state_d;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [7:0]         unit_cnt;
  logic [7:0]         frame_cnt;
  logic [7:0]         unit_load;
  logic [4:0]         bit_idx;
  logic [31:0]        shreg;
  logic [PH_W-1:0]    phase;
  logic               done_q;
  logic               tick, unit_end, enter, mark_d, frame_start, accept;

  assign tick        = (cyc_cnt == '0);
  assign unit_end    = tick && (unit_cnt == '0);
  assign enter       = (state_d != state);
  assign accept      = (state == IDLE) && tx_valid;
  assign mark_d      = state_d inside {LEAD_MARK, BIT_MARK, STOP_MARK, REP_MARK, REP_STOP};
  assign frame_start = enter && (state_d == LEAD_MARK || state_d == REP_MARK);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:       if (tx_valid) state_d = LEAD_MARK;
      LEAD_MARK:  if (unit_end) state_d = LEAD_SPACE;
      LEAD_SPACE: if (unit_end) state_d = BIT_MARK;
      BIT_MARK:   if (unit_end) state_d = BIT_SPACE;
      BIT_SPACE:  if (unit_end) state_d = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (unit_end) state_d = GAP;
      GAP: begin
        // Gap length is measured from the frame start, not from the stop mark.
        if (tick && frame_cnt == 8'(FRAME_UNITS - 1)) begin
`ifdef IR_NEC_REPEAT_EN
          state_d = tx_hold ? REP_MARK : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef IR_NEC_REPEAT_EN
      REP_MARK:   if (unit_end) state_d = REP_SPACE;
      REP_SPACE:  if (unit_end) state_d = REP_STOP;
      REP_STOP:   if (unit_end) state_d = GAP;
`endif
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    unit_load = 8'd0;
    case (state_d)
      LEAD_MARK:  unit_load = 8'd15;
      LEAD_SPACE: unit_load = 8'd7;
      BIT_SPACE:  unit_load = shreg[0] ? 8'd2 : 8'd0;
      REP_MARK:   unit_load = 8'd15;
      REP_SPACE:  unit_load = 8'd3;
      default:    unit_load = 8'd0;
    endcase
  end

`ifndef IR_NEC_REPEAT_EN
  logic unused_hold;
  assign unused_hold = tx_hold;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      unit_cnt  <= '0;
      frame_cnt <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      phase     <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= unit_end && (state == STOP_MARK || state == REP_STOP);

      if (state == IDLE || tick)
        cyc_cnt <= CYC_W'(UNIT_CYC - 1);
      else
        cyc_cnt <= cyc_cnt - 1'b1;

      if (enter)
        unit_cnt <= unit_load;
      else if (tick && unit_cnt != '0)
        unit_cnt <= unit_cnt - 1'b1;

      if (frame_start)
        frame_cnt <= '0;
      else if (tick && state != IDLE)
        frame_cnt <= frame_cnt + 1'b1;

      if (accept) begin
        shreg   <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
        bit_idx <= '0;
      end else if (state == BIT_SPACE && unit_end && bit_idx != 5'd31) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end

      if (enter && mark_d)
        phase <= '0;
      else if (phase == PH_W'(CARRIER_DIV - 1))
        phase <= '0;
      else
        phase <= phase + 1'b1;
    end
  end

  assign ir_env   = state inside {LEAD_MARK, BIT_MARK, STOP_MARK, REP_MARK, REP_STOP};
  assign ir_out   = ir_env && (phase < PH_W'(CARRIER_HIGH));
  assign busy     = (state != IDLE);
  assign tx_done  = done_q;
  assign tx_ready = (state == IDLE) && !rst;

endmodule
